// File: rtl/lfsr_share_ctrl.sv
// rtl/lfsr_share_ctrl.sv - round-robin arbiter sharing one LFSR among requesters
module lfsr_share_ctrl #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int STEPS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_lfsr_en,
    input  logic [WIDTH-1:0] i_lfsr_data,
    output logic             o_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(STEPS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STEP  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] rr_cand;

    // Round-robin pick: scan from farthest to nearest after ptr so the nearest requester wins
    always_comb begin
        win_idx = ptr;
        rr_cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            rr_cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (i_req[rr_cand]) begin
                win_idx = rr_cand;
            end
        end
    end

    // Grant sequencing: arbitrate, step the LFSR STEPS times, capture, announce
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ptr    <= IDX_W'(N_REQ - 1);
            idx    <= '0;
            cnt    <= '0;
            o_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|i_req) begin
                        idx   <= win_idx;
                        cnt   <= CNT_W'(STEPS);
                        state <= S_STEP;
                    end
                end
                S_STEP: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    o_data <= i_lfsr_data;
                    state  <= S_DONE;
                end
                default: begin
                    ptr   <= idx;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded purely from registered state and index
    always_comb begin
        o_lfsr_en = (state == S_STEP);
        o_valid   = (state == S_DONE);
        o_busy    = (state != S_IDLE);
        o_gnt     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if ((state != S_IDLE) && (idx == IDX_W'(i))) begin
                o_gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// tb/tb_lfsr_share_ctrl.sv - randomized and directed checks of lfsr_share_ctrl against a timeline model
module tb_lfsr_share_ctrl;

    localparam int NREQ  = 4;
    localparam int STEPS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b1;

    logic [3:0]  req16 = 4'b0000;
    logic [3:0]  gnt16;
    logic        valid16, en16, busy16;
    logic [15:0] data16, lfsr16;

    logic [3:0]  req1 = 4'b0000;
    logic [3:0]  gnt1;
    logic        valid1, en1, busy1;
    logic [15:0] data1, lfsr1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0;

    int          vq_cyc[$];
    logic [3:0]  vq_gnt[$];
    logic [15:0] vq_data[$];

    lfsr_share_ctrl #(.N_REQ(NREQ), .WIDTH(16), .STEPS(STEPS)) u_s16 (
        .clk(clk), .rst(rst), .i_req(req16), .o_gnt(gnt16), .o_valid(valid16),
        .o_data(data16), .o_lfsr_en(en16), .i_lfsr_data(lfsr16), .o_busy(busy16)
    );

    lfsr_share_ctrl #(.N_REQ(NREQ), .WIDTH(16), .STEPS(1)) u_s1 (
        .clk(clk), .rst(rst), .i_req(req1), .o_gnt(gnt1), .o_valid(valid1),
        .o_data(data1), .o_lfsr_en(en1), .i_lfsr_data(lfsr1), .o_busy(busy1)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] x, input int n);
        logic [15:0] v;
        v = x;
        for (int i = 0; i < n; i++) begin
            v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        end
        return v;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [3:0] req);
        int c;
        for (int k = 1; k <= NREQ; k++) begin
            c = (ptr + k) % NREQ;
            if (req[c[1:0]]) return c;
        end
        return ptr;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Environment: the two external LFSRs, seeded during reset, advanced only by enable
    always @(posedge clk) begin
        if (seed_load) begin
            lfsr16 <= 16'h0001;
            lfsr1  <= 16'h0001;
        end else begin
            if (en16) lfsr16 <= lfsr_adv(lfsr16, 1);
            if (en1)  lfsr1  <= lfsr_adv(lfsr1, 1);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (en16) en_cnt++;
        if (valid16) begin
            vq_cyc.push_back(cyc);
            vq_gnt.push_back(gnt16);
            vq_data.push_back(data16);
        end
    end

    // Timeline model: a grant occupies offsets 1..STEPS+2 after the sampling edge
    int          off = 0;
    bit          m_busy = 1'b0;
    int          m_cur = 0;
    int          m_ptr = NREQ - 1;
    logic [15:0] m_data = 16'h0;
    logic [15:0] m_lfsr = 16'h0;

    initial begin
        forever begin
            @(posedge clk);
            if (seed_load) m_lfsr = 16'h0001;
            else if (m_busy && off >= 1 && off <= STEPS) m_lfsr = lfsr_adv(m_lfsr, 1);
            if (rst) begin
                m_busy = 1'b0; off = 0; m_ptr = NREQ - 1; m_data = 16'h0;
            end else if (!m_busy) begin
                if (req16 != 4'b0000) begin
                    m_cur = rr_pick(m_ptr, req16); m_busy = 1'b1; off = 1;
                end
            end else if (off == STEPS + 2) begin
                m_busy = 1'b0; off = 0; m_ptr = m_cur;
            end else begin
                off++;
                if (off == STEPS + 2) m_data = m_lfsr;
            end
            @(negedge clk);
            check("model_en",    {31'd0, en16},    {31'd0, m_busy && off <= STEPS});
            check("model_gnt",   {28'd0, gnt16},   m_busy ? (32'd1 << m_cur) : 32'd0);
            check("model_valid", {31'd0, valid16}, {31'd0, m_busy && off == STEPS + 2});
            check("model_busy",  {31'd0, busy16},  {31'd0, m_busy});
            check("model_data",  {16'd0, data16},  {16'd0, m_data});
            if (!busy16) check("en_when_idle", {31'd0, en16}, 32'd0);
        end
    end

    task automatic wait_qsize(input int target, input string name);
        int n = 0;
        while (vq_cyc.size() < target && n < 400) begin
            @(posedge clk); #1; n++;
        end
        check(name, {31'd0, vq_cyc.size() >= target}, 32'd1);
    endtask

    task automatic wait_valid16(input string name);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!valid16 && n < 100);
        check(name, {31'd0, valid16}, 32'd1);
    endtask

    task automatic wait_busy16(input string name);
        int n = 0;
        while (!busy16 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check(name, {31'd0, busy16}, 32'd1);
    endtask

    initial begin
        int base, q0, tries;
        req16 = 4'b1111;
        req1  = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check("s1_reset_gnt",   {28'd0, gnt1},  32'd0);
        check("s1_reset_valid", {31'd0, valid1}, 32'd0);
        check("s1_reset_en",    {31'd0, en1},   32'd0);
        check("s1_reset_data",  {16'd0, data1}, 32'd0);
        rst = 1'b0;
        seed_load = 1'b0;
        req1 = 4'b0100;

        fork
            begin
                @(posedge clk); #1;
                check("s1_step_en",  {31'd0, en1},  32'd1);
                check("s1_step_gnt", {28'd0, gnt1}, 32'h4);
                req1 = 4'b0000;
                @(posedge clk); #1;
                check("s1_latch_en",    {31'd0, en1},    32'd0);
                check("s1_latch_valid", {31'd0, valid1}, 32'd0);
                @(posedge clk); #1;
                check("s1_done_valid", {31'd0, valid1}, 32'd1);
                check("s1_done_gnt",   {28'd0, gnt1},   32'h4);
                check("s1_done_data",  {16'd0, data1},  32'h0002);
                @(posedge clk); #1;
                check("s1_idle_valid", {31'd0, valid1}, 32'd0);
                check("s1_idle_busy",  {31'd0, busy1},  32'd0);
                req1 = 4'b0100;
                tries = 0;
                do begin
                    @(posedge clk); #1; tries++;
                end while (!valid1 && tries < 20);
                req1 = 4'b0000;
                check("s1_second_valid", {31'd0, valid1}, 32'd1);
                check("s1_second_data",  {16'd0, data1},  32'h0004);
                check("s1_second_gnt",   {28'd0, gnt1},   32'h4);
            end
            begin
                wait_qsize(5, "fair_timeout");
                req16 = 4'b0000;
                check("fair_g0", {28'd0, vq_gnt[0]}, 32'h1);
                check("fair_g1", {28'd0, vq_gnt[1]}, 32'h2);
                check("fair_g2", {28'd0, vq_gnt[2]}, 32'h4);
                check("fair_g3", {28'd0, vq_gnt[3]}, 32'h8);
                check("fair_g4", {28'd0, vq_gnt[4]}, 32'h1);
                check("fair_first_data", {16'd0, vq_data[0]}, 32'h002D);
                for (int i = 0; i < 4; i++)
                    check("fair_period", vq_cyc[i+1] - vq_cyc[i], 32'd19);
            end
        join

        repeat (3) @(posedge clk);
        #1;
        q0 = vq_cyc.size();
        req16 = 4'b0100;
        wait_valid16("ptr_first_timeout");
        req16 = 4'b1010;
        wait_qsize(q0 + 3, "ptr_timeout");
        req16 = 4'b0000;
        check("ptr_g2", {28'd0, vq_gnt[q0]},     32'h4);
        check("ptr_g3", {28'd0, vq_gnt[q0 + 1]}, 32'h8);
        check("ptr_g1", {28'd0, vq_gnt[q0 + 2]}, 32'h2);

        repeat (3) @(posedge clk);
        #1;
        req16 = 4'b0001;
        wait_busy16("rst_mid_busy_timeout");
        req16 = 4'b0000;
        base = en_cnt;
        q0 = vq_cyc.size();
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_en",    {31'd0, en16},   32'd0);
        check("rst_mid_gnt",   {28'd0, gnt16},  32'd0);
        check("rst_mid_count", en_cnt - base,   32'd5);
        repeat (25) @(posedge clk);
        #1;
        check("rst_mid_no_valid", vq_cyc.size() - q0, 32'd0);

        base = en_cnt;
        q0 = vq_cyc.size();
        for (int g = 0; g < 10; g++) begin
            req16 = 4'($urandom_range(1, 15));
            wait_busy16("rand_busy_timeout");
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 10)) @(posedge clk);
                #1;
                req16 = 4'b0000;
            end
            wait_valid16("rand_valid_timeout");
            req16 = 4'b0000;
            @(posedge clk); #1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rand_grants",   vq_cyc.size() - q0, 32'd10);
        check("rand_en_count", en_cnt - base,      32'(10 * STEPS));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
